sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Parametrised multi-lane serial-to-parallel deserializer with frame alignment and a valid/ready output stage. It collects `WIDTH`-bit words from `LANES` serial inputs on qualified bit strobes and delivers each complete word through a one-entry holding register. It sits between a serial front-end (bit clock enable plus frame marker) and the parallel sample datapath, replacing the fixed-width shift-left SIPO with its free-running `soc` capture.

## Interface
- `WIDTH`, 8: parallel word width; must be a multiple of `LANES`.
- `LANES`, 1: number of serial inputs shifted per beat; `BEATS = WIDTH/LANES` beats per word.
- `MSB_FIRST`, 1: 1 = first beat lands in the most significant bits; 0 = first beat lands in the least significant bits.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `en  in  1`: beat strobe; `si` is sampled only on edges where `en`=1.
- `sof  in  1`: start-of-frame; qualified by `en`, marks the current beat as beat 0 of a word.
- `si  in  LANES`: serial data; within a beat `si[LANES-1]` is the more significant bit.
- `pready  in  1`: consumer accepts `pdata` when `pvalid`=1 and `pready`=1.
- `pdata  out  WIDTH`: completed word, held stable while `pvalid`=1 and `pready`=0.
- `pvalid  out  1`: holding register full.
- `aligned  out  1`: 1 while in SHIFT state.
- `overrun  out  1`: one-cycle pulse when a completed word is dropped.
- `perr  out  1`: parity error flag for the word in `pdata` (0 when `SIPO_PARITY_EN` is undefined).

## Operation
- States: HUNT (reset state) and SHIFT; PARITY exists only with `SIPO_PARITY_EN`.
- HUNT: beats are ignored until `en`&`sof`. That beat is shifted in as beat 0, `cnt`←1, and the block goes to SHIFT.
- SHIFT: each `en` shifts one beat and increments `cnt`.
  - MSB_FIRST=1: `shreg ← {shreg[WIDTH-LANES-1:0], si}`.
  - MSB_FIRST=0: `shreg ← {si, shreg[WIDTH-1:LANES]}`.
- `en`&`sof` in SHIFT: the partial word is discarded, the beat is taken as beat 0, and `cnt`←1. No overrun and no output are produced.
- Word complete: the beat with `cnt = BEATS-1` completes the word. The completed word (including that beat) is offered to the holding register, `cnt`←0, and the block stays in SHIFT. The next beat is beat 0 whether or not `sof` is asserted.
- Holding register, at the completion edge:
  - `pvalid`=0, or `pvalid`=1 with `pready`=1: load `pdata`; `pvalid`=1.
  - `pvalid`=1 with `pready`=0: drop the new word, keep `pdata`, pulse `overrun` on the next cycle.
- Handshake without a completion: `pvalid`&`pready` clears `pvalid`; `pdata` keeps its value.
- `cnt` width is `$clog2(BEATS+1)`. With `BEATS`=1, every `en` beat completes a word.
- Reset values: `shreg`=0, `cnt`=0, state=HUNT, `pdata`=0, `pvalid`=0, `aligned`=0, `overrun`=0, `perr`=0.
- `rst` mid-word or with `pvalid`=1: all state and output are lost immediately (asynchronous); the block returns to HUNT.

## Timing
- Latency: `pvalid` and `pdata` update on the same edge that samples the last beat, so they are visible in the cycle after that beat.
- `overrun` is asserted for exactly one cycle, in the cycle after the dropped completion edge.
- `aligned` rises on the edge that samples the first `sof` beat.
- Back-to-back `en` every cycle is supported. `pready` held high sustains one word per `BEATS` cycles with no overrun.
- `pready` is not a combinational input to any output.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Each word is followed by one extra `en` beat (PARITY state) carrying even parity on `si[0]`; other lanes are ignored on that beat.
  - Handoff to the holding register occurs on the parity beat, not on the last data beat, and `perr` is loaded with (XOR of the word) ^ `si[0]`.
  - `en`&`sof` on the parity beat resynchronises: the word is discarded and the beat is taken as beat 0.
  - `perr` follows `pdata` (held and dropped together with it).
- `SIPO_PARITY_EN` undefined: no PARITY state, `perr` is tied to 0, and word period = `BEATS` beats.

## Test plan
- WIDTH=8, LANES=1, MSB_FIRST=1: `en` every cycle, `sof` on first beat, bits 1,1,0,0,0,0,0,0 -> `pdata`=8'hC0, `pvalid`=1 the cycle after beat 8.
- Same stimulus with MSB_FIRST=0 -> `pdata`=8'h03. With LANES=2, MSB_FIRST=1 and beats 2'b10,2'b11,2'b00,2'b01 -> `pdata`=8'hB1 after 4 beats.
- Beats before any `sof` are ignored (`aligned`=0, no `pvalid`). `sof` after 3 beats of a word -> partial word discarded; the next 8 beats 8'hA5 (MSB first) -> `pdata`=8'hA5.
- `pready`=0, two consecutive words 8'h11 then 8'h22 -> `pdata` stays 8'h11, one-cycle `overrun` after the second word. Then `pready`=1 -> `pvalid` clears. Completion coinciding with `pready`=1 -> `pdata`=new word, `pvalid` stays 1, no `overrun`.
- `rst` pulse asserted mid-word with `pvalid`=1 -> `pvalid`, `pdata`, `aligned` go to 0 without waiting for `clk`; the following word is captured only after a new `sof`.
- With `SIPO_PARITY_EN`: word 8'hA5 followed by parity bit 0 -> `perr`=0. Parity bit 1 -> `perr`=1. `pvalid` rises after the 9th beat.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Multi-lane serial-to-parallel deserializer with sof alignment and a one-entry valid/ready holding register.
// Define SIPO_PARITY_EN to append an even-parity beat to every word and report mismatches on perr.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sof,
  input  logic [LANES-1:0] si,
  input  logic             pready,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  output logic             aligned,
  output logic             overrun,
  output logic             perr
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SIPO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next, beat_idx;
  logic [WIDTH-1:0] shreg_reg, shreg_next, shifted, load_word;
  logic             take_beat, load;
`ifdef SIPO_PARITY_EN
  logic             load_perr;
  logic             perr_reg;
`endif

  generate
    if (BEATS == 1) begin : g_single
      assign shifted = si;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {shreg_reg[WIDTH-LANES-1:0], si};
    end else begin : g_lsb
      assign shifted = {si, shreg_reg[WIDTH-1:LANES]};
    end
  endgenerate

  // An sof beat always restarts the word, so it is indexed as beat 0 regardless of cnt.
  always_comb begin
    beat_idx   = sof ? '0 : cnt_reg;
    take_beat  = en && (sof || state_reg == SHIFT);
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    load       = 1'b0;
    load_word  = shifted;
`ifdef SIPO_PARITY_EN
    load_perr  = 1'b0;
`endif
    if (take_beat) begin
      shreg_next = shifted;
      if (beat_idx == LAST_BEAT) begin
        cnt_next = '0;
`ifdef SIPO_PARITY_EN
        state_next = PARITY;
`else
        state_next = SHIFT;
        load       = 1'b1;
`endif
      end else begin
        cnt_next   = beat_idx + ONE;
        state_next = SHIFT;
      end
    end
`ifdef SIPO_PARITY_EN
    else if (en && state_reg == PARITY) begin
      load       = 1'b1;
      load_word  = shreg_reg;
      load_perr  = (^shreg_reg) ^ si[0];
      state_next = SHIFT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
    end
  end

  // A completed word is dropped, not queued, when the holding register is still owned by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdata   <= '0;
      pvalid  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!pvalid || pready) begin
          pdata  <= load_word;
          pvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pvalid && pready) begin
        pvalid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_reg <= 1'b0;
    end else if (load && (!pvalid || pready)) begin
      perr_reg <= load_perr;
    end
  end
  assign perr = perr_reg;
`else
  assign perr = 1'b0;
`endif

  assign aligned = (state_reg != HUNT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: three instances (8x1 MSB-first, 8x1 LSB-first, 8x2 MSB-first) driven from one initial block.
module tb_sipo_deserializer;
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, sof = 1'b0, pready = 1'b1;
  logic [0:0] si = '0;
  logic en1 = 1'b0, sof1 = 1'b0;
  logic [0:0] si1 = '0;
  logic en2 = 1'b0, sof2 = 1'b0;
  logic [1:0] si2 = '0;

  logic [7:0] pdata, pdata1, pdata2;
  logic pvalid, aligned, overrun, perr;
  logic pvalid1, aligned1, overrun1, perr1;
  logic pvalid2, aligned2, overrun2, perr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof), .si(si), .pready(pready),
    .pdata(pdata), .pvalid(pvalid), .aligned(aligned), .overrun(overrun), .perr(perr));

  sipo_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .en(en1), .sof(sof1), .si(si1), .pready(pready),
    .pdata(pdata1), .pvalid(pvalid1), .aligned(aligned1), .overrun(overrun1), .perr(perr1));

  sipo_deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) dut_lanes (
    .clk(clk), .rst(rst), .en(en2), .sof(sof2), .si(si2), .pready(pready),
    .pdata(pdata2), .pvalid(pvalid2), .aligned(aligned2), .overrun(overrun2), .perr(perr2));

  task automatic idle();
    @(negedge clk);
    en = 1'b0; sof = 1'b0; si = '0;
  endtask

  // Eight data beats MSB first; in parity builds an extra parity beat (inverted when pbad).
  // rl raises pready on the beat that completes the frame.
  task automatic send_word(input logic [7:0] w, input logic s, input logic rl, input logic pbad);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b1; sof = (i == 0) ? s : 1'b0; si[0] = w[7-i];
      if (rl && i == 7 && !PAR) pready = 1'b1;
    end
    if (PAR) begin
      @(negedge clk);
      en = 1'b1; sof = 1'b0; si[0] = (^w) ^ pbad;
      if (rl) pready = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL reset_pvalid got %0b want 0", pvalid); end
    checks++; if (pdata !== 8'h00) begin errors++; $display("FAIL reset_pdata got %h want 00", pdata); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned got %0b want 0", aligned); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %0b want 0", perr); end
    rst = 1'b0;
    $display("reset: pvalid=%0b pdata=%h aligned=%0b", pvalid, pdata, aligned);
  endtask

  task automatic test_hunt();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      en = 1'b1; sof = 1'b0; si[0] = 1'b1;
    end
    idle();
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL hunt_aligned got %0b want 0", aligned); end
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL hunt_pvalid got %0b want 0", pvalid); end
    $display("hunt: aligned=%0b pvalid=%0b", aligned, pvalid);
  endtask

  task automatic test_msb_first();
    send_word(8'hC0, 1'b1, 1'b0, 1'b0);
    idle();
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL msb_pvalid got %0b want 1", pvalid); end
    checks++; if (pdata !== 8'hC0) begin errors++; $display("FAIL msb_pdata got %h want c0", pdata); end
    checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL msb_aligned got %0b want 1", aligned); end
    $display("msb_first: pdata=%h pvalid=%0b", pdata, pvalid);
    idle();
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL consume_pvalid got %0b want 0", pvalid); end
    checks++; if (pdata !== 8'hC0) begin errors++; $display("FAIL consume_pdata got %h want c0", pdata); end
    $display("consume: pdata=%h pvalid=%0b", pdata, pvalid);
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en1 = 1'b1; sof1 = (i == 0); si1[0] = seq[7-i];
    end
    if (PAR) begin
      @(negedge clk);
      en1 = 1'b1; sof1 = 1'b0; si1[0] = 1'b0;
    end
    @(negedge clk);
    en1 = 1'b0; sof1 = 1'b0;
    checks++; if (pdata1 !== 8'h03) begin errors++; $display("FAIL lsb_pdata got %h want 03", pdata1); end
    checks++; if (pvalid1 !== 1'b1) begin errors++; $display("FAIL lsb_pvalid got %0b want 1", pvalid1); end
    $display("lsb_first: pdata=%h pvalid=%0b", pdata1, pvalid1);
  endtask

  task automatic test_lanes();
    logic [1:0] beats [4];
    beats = '{2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en2 = 1'b1; sof2 = (i == 0); si2 = beats[i];
    end
    if (PAR) begin
      @(negedge clk);
      en2 = 1'b1; sof2 = 1'b0; si2 = 2'b00;
    end
    @(negedge clk);
    en2 = 1'b0; sof2 = 1'b0;
    checks++; if (pdata2 !== 8'hB1) begin errors++; $display("FAIL lanes_pdata got %h want b1", pdata2); end
    checks++; if (pvalid2 !== 1'b1) begin errors++; $display("FAIL lanes_pvalid got %0b want 1", pvalid2); end
    $display("lanes: pdata=%h pvalid=%0b", pdata2, pvalid2);
  endtask

  task automatic test_resync();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; sof = (i == 0); si[0] = 1'b1;
    end
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    idle();
    checks++; if (pdata !== 8'hA5) begin errors++; $display("FAIL resync_pdata got %h want a5", pdata); end
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL resync_pvalid got %0b want 1", pvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL resync_overrun got %0b want 0", overrun); end
    $display("resync: pdata=%h pvalid=%0b", pdata, pvalid);
  endtask

  task automatic test_overrun();
    idle();
    pready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    idle();
    checks++; if (pdata !== 8'h11) begin errors++; $display("FAIL ovr_pdata got %h want 11", pdata); end
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL ovr_pvalid got %0b want 1", pvalid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %0b want 1", overrun); end
    $display("overrun: pdata=%h overrun=%0b", pdata, overrun);
    idle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %0b want 0", overrun); end
    pready = 1'b1;
    idle();
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL ovr_drain_pvalid got %0b want 0", pvalid); end
    checks++; if (pdata !== 8'h11) begin errors++; $display("FAIL ovr_drain_pdata got %h want 11", pdata); end
    $display("drain: pdata=%h pvalid=%0b", pdata, pvalid);
  endtask

  task automatic test_back_to_back();
    pready = 1'b0;
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    idle();
    checks++; if (pdata !== 8'h33) begin errors++; $display("FAIL b2b_first_pdata got %h want 33", pdata); end
    send_word(8'h44, 1'b0, 1'b1, 1'b0);
    idle();
    checks++; if (pdata !== 8'h44) begin errors++; $display("FAIL b2b_pdata got %h want 44", pdata); end
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL b2b_pvalid got %0b want 1", pvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %0b want 0", overrun); end
    $display("back_to_back: pdata=%h pvalid=%0b overrun=%0b", pdata, pvalid, overrun);
  endtask

  task automatic test_async_reset();
    pready = 1'b0;
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    idle();
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL arst_pre_pvalid got %0b want 1", pvalid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; sof = 1'b0; si[0] = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL arst_pvalid got %0b want 0", pvalid); end
    checks++; if (pdata !== 8'h00) begin errors++; $display("FAIL arst_pdata got %h want 00", pdata); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL arst_aligned got %0b want 0", aligned); end
    $display("async_reset: pvalid=%0b pdata=%h aligned=%0b", pvalid, pdata, aligned);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    send_word(8'h66, 1'b0, 1'b0, 1'b0);
    idle();
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL arst_nosof_pvalid got %0b want 0", pvalid); end
    send_word(8'h77, 1'b1, 1'b0, 1'b0);
    idle();
    checks++; if (pdata !== 8'h77) begin errors++; $display("FAIL arst_resume_pdata got %h want 77", pdata); end
    $display("resume: pdata=%h pvalid=%0b", pdata, pvalid);
  endtask

  task automatic test_parity();
    pready = 1'b1;
    idle();
`ifdef SIPO_PARITY_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b1; sof = (i == 0); si[0] = 8'hA5 >> (7 - i);
    end
    idle();
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL par_early_pvalid got %0b want 0", pvalid); end
    @(negedge clk);
    en = 1'b1; sof = 1'b0; si[0] = 1'b0;
    idle();
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL par_pvalid got %0b want 1", pvalid); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL par_good_perr got %0b want 0", perr); end
    send_word(8'hA5, 1'b0, 1'b0, 1'b1);
    idle();
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL par_bad_perr got %0b want 1", perr); end
`else
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    idle();
    checks++; if (pdata !== 8'hA5) begin errors++; $display("FAIL par_off_pdata got %h want a5", pdata); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL par_off_perr got %0b want 0", perr); end
`endif
    $display("parity: pdata=%h perr=%0b", pdata, perr);
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_msb_first();
    test_lsb_first();
    test_lanes();
    test_resync();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
